// File: rtl/raster_box_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : raster_box_scheduler
// Description : Round-robin arbiter that loads one requester's bounding box at
//               a time into the shared fragment iterator and reports completion.
//               Optional RASTER_SCHED_FRAGCNT_EN adds a saturating fragment count.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_box_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int W          = 16,
    parameter int SETTLE_CYC = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*4*W-1:0]  req_box,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    it_nd,
    output logic [W-1:0]            it_min_x,
    output logic [W-1:0]            it_max_x,
    output logic [W-1:0]            it_min_y,
    output logic [W-1:0]            it_max_y,
    input  logic                    it_done,
    input  logic                    it_frag_rdy,
    output logic                    done_valid,
    output logic [ID_W-1:0]         done_id,
    output logic                    busy
`ifdef RASTER_SCHED_FRAGCNT_EN
    ,
    output logic [15:0]             frag_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_LAUNCH = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     cur_id;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     scan_id;
    logic                win_found;
    logic [3:0]          settle_cnt;
    logic [4*W-1:0]      box_q;
    logic                any_req;
    int                  scan_idx;
    logic [4*W-1:0]      boxes [NUM_REQ];

    assign any_req = |req_valid;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_box
        assign boxes[i] = req_box[i*4*W +: 4*W];
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        scan_id   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (req_valid[scan_id]) begin
                win_found = 1'b1;
                win_id    = scan_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        it_nd      = 1'b0;
        done_valid = 1'b0;
        done_id    = '0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // Requests may have vanished since IDLE; fall back without a pulse.
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    state_nxt         = S_LAUNCH;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LAUNCH: begin
                it_nd     = 1'b1;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (it_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                done_id    = cur_id;
                state_nxt  = any_req ? S_GRANT : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            cur_id     <= '0;
            settle_cnt <= '0;
            box_q      <= '0;
        end else begin
            case (state)
                S_GRANT: begin
                    if (win_found) begin
                        box_q  <= boxes[win_id];
                        cur_id <= win_id;
                    end
                end
                S_LAUNCH: begin
                    settle_cnt <= SETTLE_INIT;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                S_DONE: begin
                    ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign it_min_x = box_q[W-1:0];
    assign it_max_x = box_q[2*W-1:W];
    assign it_min_y = box_q[3*W-1:2*W];
    assign it_max_y = box_q[4*W-1:3*W];

`ifdef RASTER_SCHED_FRAGCNT_EN
    // Count is held after DONE so the owner can read it alongside done_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            frag_count <= '0;
        end else if (state == S_LAUNCH) begin
            frag_count <= '0;
        end else if ((state == S_SETTLE || state == S_RUN) && it_frag_rdy
                     && frag_count != 16'hFFFF) begin
            frag_count <= frag_count + 16'd1;
        end
    end
`else
    logic frag_rdy_unused;
    assign frag_rdy_unused = it_frag_rdy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_raster_box_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_box_scheduler
// Description : Randomized and directed bench with a timestamp-based reference
//               model for raster_box_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_box_scheduler;

    localparam int N  = 4;
    localparam int WW = 16;
    localparam int SC = 4;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N*4*WW-1:0]  req_box;
    logic [N-1:0]       req_ready;
    logic               it_nd;
    logic [WW-1:0]      it_min_x, it_max_x, it_min_y, it_max_y;
    logic               it_done;
    logic               it_frag_rdy;
    logic               done_valid;
    logic [1:0]         done_id;
    logic               busy;
`ifdef RASTER_SCHED_FRAGCNT_EN
    logic [15:0]        frag_count;
`endif

    raster_box_scheduler #(.NUM_REQ(N), .W(WW), .SETTLE_CYC(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_box    (req_box),
        .req_ready  (req_ready),
        .it_nd      (it_nd),
        .it_min_x   (it_min_x),
        .it_max_x   (it_max_x),
        .it_min_y   (it_min_y),
        .it_max_y   (it_max_y),
        .it_done    (it_done),
        .it_frag_rdy(it_frag_rdy),
        .done_valid (done_valid),
        .done_id    (done_id),
        .busy       (busy)
`ifdef RASTER_SCHED_FRAGCNT_EN
        ,
        .frag_count (frag_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: tracks when each event is due, as absolute cycle numbers.
    int          n = 0;
    int          grant_at = -1, launch_at = -1, run_from = -1, done_at = -1;
    bit          m_busy = 0, waiting = 0, cnt_on = 0;
    int          m_ptr = 0, m_id = 0, m_frag = 0;
    logic [63:0] m_box = '0;
    int          done_log[$];
    int          nd_log[$];
    int          dn_log[$];
    bit          ready1_seen = 0;
    int          last_frag = 0;

    always @(negedge clk) begin : mon
        logic [3:0]  e_ready;
        logic        e_nd, e_done, e_busy;
        int          e_id, w, frag_now;
        bit          found;
        logic [63:0] box_now;
        if (rst) begin
            m_busy = 0; waiting = 0; cnt_on = 0;
            grant_at = -1; launch_at = -1; run_from = -1; done_at = -1;
            m_ptr = 0; m_box = '0; m_frag = 0;
        end else begin
            e_ready = '0; e_nd = 0; e_done = 0; e_id = 0;
            e_busy = m_busy; box_now = m_box; frag_now = m_frag;
            if (n == grant_at) begin
                found = 0; w = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_ptr + k) % N]) begin
                        found = 1;
                        w = (m_ptr + k) % N;
                    end
                end
                if (found) begin
                    e_ready[w] = 1'b1;
                    m_id = w;
                    m_box = req_box[w*64 +: 64];
                    launch_at = n + 1;
                end else begin
                    m_busy = 0;
                end
            end
            if (n == launch_at) begin
                e_nd = 1; run_from = n + SC + 1; waiting = 1;
                m_frag = 0; cnt_on = 1;
            end else if (cnt_on && it_frag_rdy && m_frag < 65535) begin
                m_frag++;
            end
            if (waiting && n >= run_from && it_done) begin
                done_at = n + 1; waiting = 0; cnt_on = 0;
            end
            if (n == done_at) begin
                e_done = 1; e_id = m_id;
                m_ptr = (m_id + 1) % N;
                if (|req_valid) grant_at = n + 1;
                else m_busy = 0;
            end
            if (!e_busy && |req_valid) begin
                m_busy = 1; grant_at = n + 1;
            end
            check("busy", 64'(busy), 64'(e_busy));
            check("req_ready", 64'(req_ready), 64'(e_ready));
            check("it_nd", 64'(it_nd), 64'(e_nd));
            check("done_valid", 64'(done_valid), 64'(e_done));
            check("it_box", {it_max_y, it_min_y, it_max_x, it_min_x}, box_now);
            if (e_done) check("done_id", 64'(done_id), 64'(e_id));
`ifdef RASTER_SCHED_FRAGCNT_EN
            if (e_done) check("frag_count", 64'(frag_count), 64'(frag_now));
            if (done_valid) last_frag = int'(frag_count);
`endif
            if (req_ready[1]) ready1_seen = 1;
            if (done_valid) begin
                done_log.push_back(int'(done_id));
                dn_log.push_back(n);
            end
            if (it_nd) nd_log.push_back(n);
        end
        n++;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_box = '0; it_done = 1'b1; it_frag_rdy = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single request on requester 2 with a unit box.
        done_log.delete();
        req_box[2*64 +: 64] = {16'h3C00, 16'h0000, 16'h3C00, 16'h0000};
        req_valid = 4'b0100; it_done = 1'b0;
        tick(2);
        req_valid = '0;
        tick(8);
        it_done = 1'b1;
        tick(4);
        check("p1_count", 64'(done_log.size()), 64'd1);
        if (done_log.size() > 0) check("p1_done_id", 64'(done_log[0]), 64'd2);

        // All requesters held with it_done high: strict rotation, minimum timing.
        do_reset();
        done_log.delete(); nd_log.delete(); dn_log.delete();
        req_valid = 4'b1111;
        tick(43);
        req_valid = '0;
        tick(12);
        check("p2_count", 64'(done_log.size() >= 5), 64'd1);
        if (done_log.size() >= 5) begin
            check("p2_id0", 64'(done_log[0]), 64'd0);
            check("p2_id1", 64'(done_log[1]), 64'd1);
            check("p2_id2", 64'(done_log[2]), 64'd2);
            check("p2_id3", 64'(done_log[3]), 64'd3);
            check("p2_id4", 64'(done_log[4]), 64'd0);
        end
        if (nd_log.size() >= 5 && dn_log.size() >= 5) begin
            for (int i = 0; i < 4; i++) begin
                check("p2_turnaround", 64'(nd_log[i+1] - dn_log[i]), 64'd2);
                check("p2_launch_to_done", 64'(dn_log[i] - nd_log[i]), 64'(SC + 2));
            end
        end

        // One-cycle pulse on requester 1 while another box runs is never granted.
        ready1_seen = 0;
        req_valid = 4'b0001; it_done = 1'b0;
        tick(2);
        req_valid = '0;
        tick(3);
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        tick(5);
        it_done = 1'b1;
        tick(5);
        check("p4_ready1_never", 64'(ready1_seen), 64'd0);

        // Reset during RUN aborts silently; ptr returns to 0 so requester 3 wins.
        do_reset();
        req_valid = 4'b0001; it_done = 1'b0;
        tick(2);
        req_valid = '0;
        tick(8);
        rst = 1'b1; req_valid = 4'b1000;
        tick(1);
        rst = 1'b0;
        done_log.delete();
        tick(3);
        req_valid = '0;
        tick(3);
        it_done = 1'b1;
        tick(10);
        check("p5_count", 64'(done_log.size()), 64'd1);
        if (done_log.size() > 0) check("p5_first_id", 64'(done_log[0]), 64'd3);

        // Randomized traffic, including occasional resets.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
            for (int j = 0; j < N * 2; j++) req_box[j*32 +: 32] = $urandom;
            it_done     = ($urandom_range(0, 3) == 0);
            it_frag_rdy = 1'($urandom);
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick(1);
            rst = 1'b0;
        end
        req_valid = '0; it_done = 1'b1; it_frag_rdy = 1'b0;
        tick(12);

`ifdef RASTER_SCHED_FRAGCNT_EN
        // Twelve fragment strobes, then a saturating run.
        do_reset();
        req_valid = 4'b0001; it_done = 1'b0;
        tick(2);
        req_valid = '0;
        tick(1);
        for (int i = 0; i < 12; i++) begin
            it_frag_rdy = 1'b1;
            tick(1);
            it_frag_rdy = 1'b0;
            tick(1);
        end
        it_done = 1'b1;
        tick(4);
        check("frag_12", 64'(last_frag), 64'd12);

        req_valid = 4'b0001; it_done = 1'b0;
        tick(2);
        req_valid = '0;
        tick(1);
        it_frag_rdy = 1'b1;
        tick(70000);
        it_frag_rdy = 1'b0;
        it_done = 1'b1;
        tick(4);
        check("frag_sat", 64'(last_frag), 64'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
